// File: rtl/mem_arbiter_rr_if.sv
// Request/response and byte-serial memory bus bundle for mem_arbiter_rr.
// Port p of every packed request/response field occupies slice p.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
);
  logic [7:0]                      mem_din;
  logic [7:0]                      mem_dout;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_wr;
  logic                            io_buffer_full;
  logic [NUM_PORTS-1:0]            req_en;
  logic [NUM_PORTS-1:0]            req_wr;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*SIZE_W-1:0]     req_size;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            resp_done;
  logic [DATA_WIDTH-1:0]           resp_rdata;

  // Arbiter side
  modport slave (
    input  mem_din, io_buffer_full, req_en, req_wr, req_addr, req_size, req_wdata,
    output mem_dout, mem_addr, mem_wr, resp_done, resp_rdata
  );

  // Requester / memory side
  modport master (
    output mem_din, io_buffer_full, req_en, req_wr, req_addr, req_size, req_wdata,
    input  mem_dout, mem_addr, mem_wr, resp_done, resp_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin N-port byte-serial memory controller: serialises 1..DATA_WIDTH/8
// byte reads/writes onto the 8-bit RAM/UART bus and returns assembled load data.
module mem_arbiter_rr #(
  parameter int unsigned          NUM_PORTS  = 2,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          SIZE_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
  parameter logic [NUM_PORTS-1:0] FLUSH_MASK = NUM_PORTS'('b10),
  parameter logic [1:0]           IO_PREFIX  = 2'b11
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  input logic             clr,
  mem_arbiter_rr_if.slave bus
);
  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = SIZE_W + 1;

  typedef enum logic [1:0] {IDLE, XFER, CAPT, GAP} state_t;

  state_t                state_q, state_n;
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_n;
  logic [PORT_W-1:0]     port_q, port_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [NUM_PORTS-1:0]  done_q, done_n;

  logic [ADDR_WIDTH-1:0] p_addr  [NUM_PORTS];
  logic [SIZE_W-1:0]     p_size  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] p_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  elig;

  logic                  gnt_vld;
  logic [PORT_W-1:0]     gnt;
  logic [PORT_W-1:0]     sel;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [SIZE_W-1:0]     cur_size;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  cur_wr;
  logic                  last;
  logic                  flush;
  logic                  mem_wr_c;
  logic [7:0]            mem_dout_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;

  // Unpack request fields; IO-space stores stall while the UART buffer is full
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_addr[p]  = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      p_size[p]  = bus.req_size[p*SIZE_W +: SIZE_W];
      p_wdata[p] = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      elig[p]    = bus.req_en[p] && !clr &&
                   !(bus.req_wr[p] && bus.io_buffer_full &&
                     (p_addr[p][17:16] == IO_PREFIX));
    end
  end

  // First eligible port scanning upward from rr_ptr with wrap-around
  always_comb begin
    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] idx;
    sum     = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, rr_ptr_q} + (PORT_W+1)'(i);
      if (sum >= (PORT_W+1)'(NUM_PORTS)) sum = sum - (PORT_W+1)'(NUM_PORTS);
      idx = PORT_W'(sum);
      if (!gnt_vld && elig[idx] && rdy && rst && state_q == IDLE) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  // Request fields are read live from the granted port
  assign sel       = (state_q == IDLE) ? gnt : port_q;
  assign cur_addr  = p_addr[sel];
  assign cur_size  = p_size[sel];
  assign cur_wdata = p_wdata[sel];
  assign cur_wr    = bus.req_wr[sel];
  assign last      = (cnt_q == CNT_W'(cur_size));
  assign flush     = clr && !cur_wr && FLUSH_MASK[port_q];

  always_comb begin
    mem_wr_c   = 1'b0;
    mem_addr_c = '0;
    mem_dout_c = '0;
    if (gnt_vld || state_q == XFER) begin
      mem_addr_c = cur_addr + ADDR_WIDTH'(cnt_q);
      mem_wr_c   = cur_wr;
      if (cur_wr) mem_dout_c = 8'(cur_wdata >> (8 * cnt_q));
    end
  end

  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    port_n   = port_q;
    cnt_n    = cnt_q;
    rbuf_n   = rbuf_q;
    rdata_n  = rdata_q;
    done_n   = done_q;
    unique case (state_q)
      IDLE: if (gnt_vld) begin
        port_n   = gnt;
        rr_ptr_n = (gnt == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt + PORT_W'(1);
        rbuf_n   = '0;
        cnt_n    = CNT_W'(1);
        if (!last)       state_n = XFER;
        else if (cur_wr) begin
          state_n = GAP;
          done_n  = NUM_PORTS'(1) << gnt;
        end else         state_n = CAPT;
      end
      XFER: if (flush) begin
        state_n = IDLE;
        cnt_n   = '0;
        rbuf_n  = '0;
      end else begin
        // Read data lags the address by one cycle
        if (!cur_wr) rbuf_n[8*(cnt_q - CNT_W'(1)) +: 8] = bus.mem_din;
        cnt_n = cnt_q + CNT_W'(1);
        if (last) begin
          if (cur_wr) begin
            state_n = GAP;
            done_n  = NUM_PORTS'(1) << port_q;
          end else state_n = CAPT;
        end
      end
      CAPT: if (flush) begin
        state_n = IDLE;
        cnt_n   = '0;
        rbuf_n  = '0;
      end else begin
        rbuf_n[8*(cnt_q - CNT_W'(1)) +: 8] = bus.mem_din;
        rdata_n = rbuf_n;
        done_n  = NUM_PORTS'(1) << port_q;
        cnt_n   = '0;
        state_n = GAP;
      end
      GAP: begin
        state_n = IDLE;
        done_n  = '0;
        rdata_n = '0;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // rdy low freezes every register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      port_q   <= '0;
      cnt_q    <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
    end else if (rdy) begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      port_q   <= port_n;
      cnt_q    <= cnt_n;
      rbuf_q   <= rbuf_n;
      rdata_q  <= rdata_n;
      done_q   <= done_n;
    end
  end

  assign bus.mem_wr     = mem_wr_c && rdy;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_dout   = mem_dout_c;
  assign bus.resp_done  = rdy ? done_q : '0;
  assign bus.resp_rdata = rdy ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: directed transactions push expected
// completions (port, data, cycle); a negedge monitor pops and compares them.
module tb_mem_arbiter_rr;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clr = 1'b0;

  mem_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_W(SW)) bus ();

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_W(SW),
                   .FLUSH_MASK(2'b10), .IO_PREFIX(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory with one-cycle read latency, frozen together with the core on rdy low
  logic [7:0] mem [int unsigned];
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_dout;
      bus.mem_din <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
    end
  end

  typedef struct {
    logic [NP-1:0] done;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   t0, t1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [NP-1:0] d, input logic [DW-1:0] r, input int c);
    exp_t e;
    e.done = d; e.rdata = r; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic issue(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [SW-1:0] s, input logic [DW-1:0] wd);
    bus.req_wr[p]            = wr;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_size[p*SW +: SW] = s;
    bus.req_wdata[p*DW +: DW] = wd;
    bus.req_en[p]            = 1'b1;
  endtask

  // Requester holds its request until its done pulse, then drops it in the GAP cycle
  task automatic wait_done(input int p);
    int n;
    n = 0;
    while (!bus.resp_done[p] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen_p%0d", p), 64'(bus.resp_done[p]), 64'd1);
    bus.req_en[p] = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input int unsigned a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  always @(negedge clk) begin
    if (bus.resp_done != '0) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(bus.resp_done), 64'd0);
      else begin
        sb_e = sb.pop_front();
        chk("done_port", 64'(bus.resp_done), 64'(sb_e.done));
        chk("done_rdata", 64'(bus.resp_rdata), 64'(sb_e.rdata));
        chk("done_cycle", 64'(cyc), 64'(sb_e.cyc));
      end
    end else if (bus.resp_rdata != '0) begin
      chk("rdata_without_done", 64'(bus.resp_rdata), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.req_en = '0; bus.req_wr = '0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_wdata = '0; bus.io_buffer_full = 1'b0;
    mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h44;
    mem[32'h40] = 8'hA0; mem[32'h41] = 8'hA1; mem[32'h50] = 8'hB0; mem[32'h51] = 8'hB1;

    // Reset: a pending request must not reach the bus
    issue(0, 1'b1, 32'h1234, 2'd0, 32'h99);
    repeat (2) @(negedge clk);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
    chk("rst_resp_done", 64'(bus.resp_done), 64'd0);
    bus.req_en = '0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch: 4-byte read on port 0
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b01, 32'h44332211, t0 + 5);
    issue(0, 1'b0, 32'h1000, 2'd3, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_addr", 64'(bus.mem_addr), 64'(32'h1000 + k));
    end
    wait_done(0);
    chk("fetch_gap_addr", 64'(bus.mem_addr), 64'd0);

    // Store halfword on port 1
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b10, 32'h0, t0 + 2);
    issue(1, 1'b1, 32'h20, 2'd1, 32'hBEEF);
    @(negedge clk);
    chk("sh_wr0", 64'(bus.mem_wr), 64'd1);
    chk("sh_addr0", 64'(bus.mem_addr), 64'h20);
    chk("sh_dout0", 64'(bus.mem_dout), 64'hEF);
    @(negedge clk);
    chk("sh_addr1", 64'(bus.mem_addr), 64'h21);
    chk("sh_dout1", 64'(bus.mem_dout), 64'hBE);
    @(negedge clk);
    chk("sh_gap_wr", 64'(bus.mem_wr), 64'd0);
    wait_done(1);
    chk("sh_mem", 64'({mem[32'h21], mem[32'h20]}), 64'hBEEF);

    // Round-robin: both ports issue back-to-back byte reads
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b01, 32'hA0, t0 + 2);
    push_exp(2'b10, 32'hB0, t0 + 5);
    push_exp(2'b01, 32'hA1, t0 + 8);
    push_exp(2'b10, 32'hB1, t0 + 11);
    issue(0, 1'b0, 32'h40, 2'd0, 32'h0);
    issue(1, 1'b0, 32'h50, 2'd0, 32'h0);
    fork
      begin wait_done(0); @(posedge clk); #1; issue(0, 1'b0, 32'h41, 2'd0, 32'h0); wait_done(0); end
      begin wait_done(1); @(posedge clk); #1; issue(1, 1'b0, 32'h51, 2'd0, 32'h0); wait_done(1); end
    join

    // Flush of a masked read: no completion, controller idle at T0+3
    @(posedge clk); #1; t0 = cyc;
    issue(1, 1'b0, 32'h1000, 2'd3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk); bus.req_en[1] = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    push_exp(2'b01, 32'hA0, t0 + 5);
    issue(0, 1'b0, 32'h40, 2'd0, 32'h0);
    @(negedge clk);
    chk("flush_regrant_addr", 64'(bus.mem_addr), 64'h40);
    wait_done(0);

    // Flush during a store: the store completes
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b10, 32'h0, t0 + 4);
    issue(1, 1'b1, 32'h60, 2'd3, 32'hCAFEF00D);
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    wait_done(1);
    chk("flush_store_mem", 64'(mem_word(32'h60)), 64'hCAFEF00D);

    // UART back-pressure on an IO store
    bus.io_buffer_full = 1'b1;
    @(posedge clk); #1;
    issue(1, 1'b1, 32'h30000, 2'd0, 32'h5A);
    repeat (3) begin
      @(negedge clk);
      chk("uart_block_wr", 64'(bus.mem_wr), 64'd0);
      chk("uart_block_addr", 64'(bus.mem_addr), 64'd0);
    end
    @(posedge clk); #1; t1 = cyc;
    push_exp(2'b10, 32'h0, t1 + 1);
    bus.io_buffer_full = 1'b0;
    @(negedge clk);
    chk("uart_wr", 64'(bus.mem_wr), 64'd1);
    chk("uart_addr", 64'(bus.mem_addr), 64'h30000);
    chk("uart_dout", 64'(bus.mem_dout), 64'h5A);
    wait_done(1);
    chk("uart_mem", 64'(mem[32'h30000]), 64'h5A);

    // rdy low for 3 cycles mid-read: result 3 cycles late, data intact
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b01, 32'h44332211, t0 + 8);
    issue(0, 1'b0, 32'h1000, 2'd3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("freeze_addr_hold", 64'(bus.mem_addr), 64'h1002);
    end
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(0);

    // rdy low during a store byte and during the GAP cycle
    @(posedge clk); #1; t0 = cyc;
    push_exp(2'b10, 32'h0, t0 + 4);
    issue(1, 1'b1, 32'h70, 2'd1, 32'h1234);
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    chk("freeze_wr_low", 64'(bus.mem_wr), 64'd0);
    @(posedge clk); #1 rdy = 1'b1;
    @(negedge clk);
    chk("freeze_wr_resume", 64'(bus.mem_wr), 64'd1);
    chk("freeze_addr_resume", 64'(bus.mem_addr), 64'h71);
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    chk("freeze_done_low", 64'(bus.resp_done), 64'd0);
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(1);
    chk("freeze_store_mem", 64'({mem[32'h71], mem[32'h70]}), 64'h1234);

    // Async reset mid-write; port 0 wins the first grant after release
    @(posedge clk); #1;
    issue(0, 1'b1, 32'h80, 2'd3, 32'h01020304);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wr", 64'(bus.mem_wr), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_wr", 64'(bus.mem_wr), 64'd0);
    chk("async_rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("async_rst_dout", 64'(bus.mem_dout), 64'd0);
    chk("async_rst_done", 64'(bus.resp_done), 64'd0);
    issue(1, 1'b0, 32'h50, 2'd0, 32'h0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    t1 = cyc;
    push_exp(2'b01, 32'h0, t1 + 4);
    push_exp(2'b10, 32'hB0, t1 + 7);
    @(negedge clk);
    chk("post_rst_grant_addr", 64'(bus.mem_addr), 64'h80);
    chk("post_rst_grant_dout", 64'(bus.mem_dout), 64'h04);
    wait_done(0);
    wait_done(1);
    chk("post_rst_mem", 64'(mem_word(32'h80)), 64'h01020304);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised byte-serial memory controller that sits between the RAM/UART bus and NUM_PORTS requesters (IF, LSB, and later a D-cache or prefetcher). It arbitrates round-robin, serialises 1..DATA_WIDTH/8-byte reads and writes onto the 8-bit memory bus, and returns assembled load data to the granted port. Compared with the two-port controller it replaces, it adds:

- N ports with fair round-robin arbitration;
- a per-port flush mask;
- UART back-pressure handling;
- a freeze on rdy-low instead of a restart.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters, 2..8; port 0 has priority after reset.
- ADDR_WIDTH, 32: request address width; mem_addr is the same width.
- DATA_WIDTH, 32: max transfer width, a multiple of 8, 8..64; NB = DATA_WIDTH/8.
- SIZE_W, clog2(NB) (1 minimum): width of a size field; a value s means s+1 bytes.
- FLUSH_MASK, 'b10: bit p set means clr aborts an in-flight read of port p.
- IO_PREFIX, 2'b11: an address with addr[17:16] == IO_PREFIX is UART space.

Ports (packed buses, port p occupies slice p):
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- rdy  in  1  global enable; low freezes all state.
- clr  in  1  pipeline flush (branch mispredict).
- mem_din  in  8  read data byte from RAM/UART.
- mem_dout  out  8  write data byte.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART TX buffer full.
- req_en  in  NUM_PORTS  request valid; held with its fields until done.
- req_wr  in  NUM_PORTS  1 = store.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  start address.
- req_size  in  NUM_PORTS*SIZE_W  bytes-1.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  store data, little-endian.
- resp_done  out  NUM_PORTS  one-hot completion pulse, 1 cycle.
- resp_rdata  out  DATA_WIDTH  load data, zero-extended; valid with done, 0 otherwise.

## Operation
Reset values:
- state = IDLE, rr_ptr = 0, byte counter = 0, shift register = 0.
- resp_done = 0, resp_rdata = 0.
- Combinational bus outputs at reset: mem_wr = 0, mem_addr = 0, mem_dout = 0.

States:
- IDLE: wait for an eligible request.
- XFER: byte transfer in progress; counter k = 0..size.
- CAPT: read only; capture the last byte.
- GAP: one dead cycle after every transaction.

Eligibility and arbitration:
- Port p is eligible if req_en[p] = 1, clr = 0, and it is not a write to IO space while io_buffer_full = 1.
- In IDLE with rdy = 1, grant the first eligible port scanning from rr_ptr upward, with wrap-around.
- On grant, rr_ptr <= (grant+1) mod NUM_PORTS.
- Grant, address and byte 0 are driven combinationally in the grant cycle. Latch the port index only; the request fields are read live, because the requester holds them.

Per-byte behaviour:
- Byte k: mem_addr = req_addr + k.
- Write: mem_wr = 1, mem_dout = wdata[8k+7:8k].
- Read: mem_wr = 0. The byte arrives on mem_din one cycle later and is stored at rdata[8(k)+7:8k].

Transaction end:
- Write: after the size+1 bytes, enter GAP and pulse resp_done.
- Read: after the last address, enter CAPT, where mem_wr = 0 and mem_addr = 0. The last byte is captured in CAPT; then enter GAP with resp_done and resp_rdata set.
- GAP: mem_wr = 0, mem_addr = 0. Return to IDLE next cycle.

clr behaviour:
- In XFER or CAPT of a read whose FLUSH_MASK bit is set: go to IDLE next edge, no done pulse, shift register cleared.
- Writes and unmasked reads always complete.
- clr in IDLE blocks grants in that cycle.

rdy = 0:
- All registers hold.
- mem_wr is forced to 0, so no spurious write.
- resp_done is forced low and re-asserts when rdy returns if it was pending.

Address arithmetic:
- Modulo 2^ADDR_WIDTH; no alignment check.
- Multi-byte IO writes are a software error; they are only gated on io_buffer_full at grant.

## Timing
- Grant in cycle T0, request size n = size+1 bytes.
- Write: bytes on the bus at T0..T0+n-1. resp_done is high in T0+n (GAP). The next grant is possible at T0+n+1. Throughput is n+1 cycles per write.
- Read: addresses at T0..T0+n-1. Byte k is sampled at the edge ending T0+k+1. resp_done and resp_rdata are high in T0+n+1 (GAP). The next grant is at T0+n+2.
- Fetch, 4 bytes: done at T0+5.
- Back-to-back requests from all ports are served in strict rotation, with no starvation.
- Async reset mid-transaction returns to IDLE immediately. Outputs take their reset values without waiting for a clock edge.

## Test plan
- Fetch:
  - Stimulus: port 0 reads 4 bytes at 0x1000, memory bytes 11 22 33 44; grant at T0.
  - Response: mem_addr 0x1000..0x1003 at T0..T0+3; resp_done = 01 and resp_rdata = 0x44332211 at T0+5; GAP at T0+5, no grant then.
- Store halfword:
  - Stimulus: port 1 writes 0xBEEF at 0x20, size = 1.
  - Response: wr = 1, addr 0x20, dout EF at T0; 0x21 / BE at T0+1; mem_wr = 0 and resp_done = 10 at T0+2.
- Round-robin:
  - Stimulus: both ports request byte reads continuously.
  - Response: grants alternate 0,1,0,1; each byte read takes 3 cycles; no port is granted twice in a row.
- Flush:
  - Stimulus: port 1 (masked) word read, clr at T0+2.
  - Response: IDLE at T0+3, no resp_done, rdata 0.
  - Stimulus: same with a store.
  - Response: the store completes normally.
- UART back-pressure:
  - Stimulus: port 1 writes 0x30000 while io_buffer_full = 1, port 0 idle.
  - Response: no grant, mem_wr = 0.
  - Stimulus: io_buffer_full drops.
  - Response: grant the same cycle; dout is the byte.
- rdy freeze / async reset:
  - Stimulus: rdy = 0 for 3 cycles mid-read.
  - Response: mem_wr = 0, result delayed exactly 3 cycles, data intact.
  - Stimulus: rst = 0 mid-write.
  - Response: outputs are 0 immediately; the first grant after release goes to port 0.
